mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 29 ++
 rtl/mult_arb_rr.sv | 63 ++++++
 rtl/mult_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester count, wait-counter width and a
// one-hot helper used by both the arbiter top and the grant sub-module.
package mult_arb_pkg;

  // Number of requesters sharing the multiplier.
  localparam int N_REQ = 2;

  // Width of the multiplier-latency countdown (holds MUL_LAT-1, MUL_LAT <= 7).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester index to one-hot requester mask.
  function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
    logic [N_REQ-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/mult_arb_rr.sv
// Grant selection and round-robin pointer for the multiplier arbiter.
// Latency: grant is combinational from valid; pointer updates on the accept edge.
// Backpressure: grants only while enabled; a single request wins outright.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   valid      - per-requester request
//   enable     - arbiter may grant this cycle (idle and not in reset)
//   accept     - the granted request was taken this cycle
//   grant      - one-hot grant mask (all zero when nothing is granted)
//   grant_idx  - index of the granted requester
//
// Build option: MULT_ARB_FIXED_PRIO_EN makes requester 0 win every tie; the
// pointer is then held at its reset value of 0 and never updated.
module mult_arb_rr
  import mult_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic             grant_idx
);

  // Requester that wins when both are valid.
  logic ptr;

  always_comb begin
    grant_idx = 1'b0;
    grant     = '0;
    case (valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ptr;
      default: grant_idx = 1'b0;
    endcase
    if (enable && (valid != '0)) begin
      grant = req_onehot(grant_idx);
    end
  end

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Pointer pinned at 0 so every tie resolves to requester 0.
  logic unused_accept;
  assign unused_accept = accept;

  always_ff @(posedge clk) begin
    ptr <= 1'b0;
  end
`else
  // After serving g, the other requester gets the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_idx;
    end
  end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one external multiplier, one operation in flight.
// Latency: handshake in cycle N -> rsp_valid first high in cycle N+MUL_LAT+1.
// Backpressure: response held until rsp_ready of the granted requester; no new grant until then.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-requester operand handshake (2 bits)
//   req_a, req_b        - operands, requester i in slice [i*BITS +: BITS]
//   rsp_valid/rsp_ready - per-requester product handshake (2 bits)
//   rsp_p               - product (2*BITS), shared by both requesters
//   mul_a, mul_b, mul_p - interface to the shared multiplier
//   busy                - high whenever the arbiter is not idle
//
// Build option: MULT_ARB_FIXED_PRIO_EN (see mult_arb_rr) selects fixed priority
// to requester 0 instead of round-robin.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int BITS    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*BITS-1:0] req_a,
  input  logic [N_REQ*BITS-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [2*BITS-1:0]     rsp_p,
  output logic [BITS-1:0]       mul_a,
  output logic [BITS-1:0]       mul_b,
  input  logic [2*BITS-1:0]     mul_p,
  output logic                  busy
);

  // The countdown starts at MUL_LAT-1 so the product is sampled in the
  // MUL_LAT-th WAIT cycle.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             gnt_q;
  logic [N_REQ-1:0] grant;
  logic             grant_idx;
  logic             req_hs;
  logic             rsp_hs;
  logic [BITS-1:0]  sel_a;
  logic [BITS-1:0]  sel_b;

  mult_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .enable    ((state == IDLE) && !rst),
    .accept    (req_hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  // grant is only non-zero in IDLE, so this is the IDLE accept condition.
  assign req_hs    = (req_valid & grant) != '0;
  // Only the granted requester's rsp_ready can retire the response.
  assign rsp_hs    = (state == RESP) && rsp_ready[gnt_q];

  assign sel_a = grant_idx ? req_a[2*BITS-1:BITS] : req_a[BITS-1:0];
  assign sel_b = grant_idx ? req_b[2*BITS-1:BITS] : req_b[BITS-1:0];

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter and datapath registers. mul_a/mul_b only change on a new
  // accept, so they keep the last operands outside WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      gnt_q <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      rsp_p <= '0;
    end else begin
      if ((state == IDLE) && req_hs) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        cnt   <= LAT_M1;
        gnt_q <= grant_idx;
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          rsp_p <= mul_p;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Status outputs are forced low for the whole reset cycle, not only
  // after the reset edge.
  assign rsp_valid = ((state == RESP) && !rst) ? req_onehot(gnt_q) : '0;
  assign busy      = (state != IDLE) && !rst;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a one-register model multiplier.
// Latency: n/a. Backpressure: exercised by holding rsp_ready low.
// A transaction-level model checks every cycle; directed sequences pin literals.
module tb_mult_arbiter;

  localparam int BITS    = 4;
  localparam int MUL_LAT = 2;
`ifdef MULT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b, rsp_p, mul_p;
  logic [3:0] mul_a, mul_b;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model multiplier: product valid one cycle after the operands change,
  // which is what MUL_LAT=2 requires given the arbiter samples at count 0.
  always @(posedge clk) mul_p <= {4'd0, mul_a} * {4'd0, mul_b};

  mult_arbiter #(.BITS(BITS), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit         m_out   = 1'b0;   // an operation is accepted and not yet consumed
  logic       m_idx   = 1'b0;
  logic [3:0] m_a     = '0;
  logic [3:0] m_b     = '0;
  logic [7:0] m_prod  = '0;
  int         m_due   = 0;
  logic       m_ptr   = 1'b0;
  bit         prev_rst = 1'b0;

  function automatic int pick(input logic [1:0] v, input logic p);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) return FIXED ? 0 : int'(p);
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int         g;
    logic [1:0] e_rr;
    logic [1:0] e_rv;
    if (prev_rst) begin
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
    end
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      m_out = 1'b0;
      m_ptr = 1'b0;
    end else begin
      g    = m_out ? -1 : pick(req_valid, m_ptr);
      e_rr = (g < 0) ? 2'b00 : (2'b01 << g);
      e_rv = (m_out && cyc >= m_due) ? (2'b01 << m_idx) : 2'b00;
      chk("m_req_ready", req_ready, e_rr);
      chk("m_rsp_valid", rsp_valid, e_rv);
      chk("m_busy", busy, m_out);
      if (m_out) begin
        chk("m_mul_a", mul_a, m_a);
        chk("m_mul_b", mul_b, m_b);
      end
      if (e_rv != 2'b00) chk("m_rsp_p", rsp_p, m_prod);
      if (e_rv != 2'b00 && rsp_ready[m_idx]) begin
        m_out = 1'b0;
      end else if (g >= 0) begin
        m_out  = 1'b1;
        m_idx  = g[0];
        m_a    = req_a[g*4 +: 4];
        m_b    = req_b[g*4 +: 4];
        m_prod = {4'd0, m_a} * {4'd0, m_b};
        m_due  = cyc + MUL_LAT + 1;
        if (!FIXED) m_ptr = ~g[0];
      end
    end
    prev_rst = rst;
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic wait_hs(output int idx, output int hc);
    idx = -1;
    hc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        idx = req_ready[1] ? 1 : 0;
        hc  = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL hs_timeout: no request accepted within 20 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_rsp(input int idx, output int rc, output logic [7:0] p);
    rc = 0;
    p  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin
        rc = cyc;
        p  = rsp_p;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL rsp_timeout: no rsp_valid[%0d] within 40 cycles (cycle %0d)", idx, cyc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         gi, hc, rc;
    logic [7:0] p;
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    repeat (3) step();
    rst       = 1'b0;
    rsp_ready = 2'b11;

    // Single requester 0: 3 x 5.
    req_a = 8'h03; req_b = 8'h05; req_valid = 2'b01;
    wait_hs(gi, hc);
    chk("s1_grant", gi, 0);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("s1_ready_one_cycle", req_ready, 2'b00);
    wait_rsp(0, rc, p);
    chk("s1_latency", rc - hc, 3);
    chk("s1_product", p, 15);

    // Reset, then both valid continuously: 2x7 on 0, 15x15 on 1.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 8'hF2; req_b = 8'hF7; req_valid = 2'b11;
    wait_hs(gi, hc);
    chk("s2_grant1", gi, 0);
    wait_rsp(0, rc, p);
    chk("s2_prod1", p, 14);
    wait_hs(gi, hc);
    chk("s2_grant2", gi, FIXED ? 0 : 1);
    wait_rsp(FIXED ? 0 : 1, rc, p);
    chk("s2_prod2", p, FIXED ? 14 : 225);
    wait_hs(gi, hc);
    chk("s2_grant3", gi, 0);
    step();
    req_valid = 2'b00;
    wait_rsp(0, rc, p);
    chk("s2_prod3", p, 14);

    // Requester 1 alone, response held 10 cycles; other bits ignored.
    step();
    req_valid = 2'b10; rsp_ready = 2'b01;
    wait_hs(gi, hc);
    chk("s3_grant", gi, 1);
    step();
    req_valid = 2'b11;
    wait_rsp(1, rc, p);
    chk("s3_prod", p, 225);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s3_hold_rsp_valid", rsp_valid, 2'b10);
      chk("s3_hold_rsp_p", rsp_p, 225);
      chk("s3_hold_req_ready", req_ready, 2'b00);
      chk("s3_hold_busy", busy, 1);
    end
    step();
    rsp_ready = 2'b11; req_valid = 2'b00;

    // Reset pulsed during WAIT abandons the operation.
    step();
    req_a = 8'h03; req_b = 8'h05; req_valid = 2'b01;
    wait_hs(gi, hc);
    step();
    req_valid = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s4_rsp_valid", rsp_valid, 2'b00);
    chk("s4_busy", busy, 0);
    chk("s4_req_ready", req_ready, 2'b00);
    chk("s4_rsp_p", rsp_p, 0);
    chk("s4_mul_a", mul_a, 0);
    chk("s4_mul_b", mul_b, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s4_no_rsp", rsp_valid, 2'b00);
    end
    step();
    req_a = 8'h04; req_b = 8'h04; req_valid = 2'b01;
    wait_hs(gi, hc);
    step();
    req_valid = 2'b00;
    wait_rsp(0, rc, p);
    chk("s4_prod", p, 16);

    // All 16x16 operand pairs on requester 1.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] a4, b4;
        a4 = a[3:0];
        b4 = b[3:0];
        step();
        req_a = {a4, 4'd0}; req_b = {b4, 4'd0}; req_valid = 2'b10;
        wait_hs(gi, hc);
        step();
        req_valid = 2'b00;
        wait_rsp(1, rc, p);
        chk("s5_exhaustive", p, a * b);
      end
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
